dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Handshaked, multi-cycle data-memory responder. It sits at the far end of the MEM-stage load/store request channel and replaces the single-cycle data_memory on that channel.
- It accepts one load or store per transaction and applies RV32I func3 width and sign rules.
- It returns read data or a store acknowledgement after a programmable latency.
- It flags misaligned and out-of-range accesses as errors instead of performing them.

Parameters:
- DATA_WIDTH, 32, data and address width.
- DEPTH_WORDS, 1024, number of 32-bit words of storage (power of two).
- LATENCY, 2, cycles from request acceptance to resp_valid; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_func3  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  DATA_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, LSB-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts the response.
- resp_rdata  out  DATA_WIDTH  load result after extension; 0 for stores and errors.
- resp_err  out  1  access was misaligned, out of range, or had an illegal func3.
- busy  out  1  high whenever state is not IDLE; used as a pipeline stall source.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, latency counter=0, request capture registers=0.
- Storage array contents are not reset.
- States are IDLE, WAIT, RESP.
- IDLE: req_ready=1. When req_valid=1, the request is accepted at the clock edge.
  - Capture we, func3, addr and wdata.
  - Load counter with LATENCY-1.
  - If LATENCY=1, go directly to RESP; otherwise go to WAIT.
- WAIT: counter decrements each cycle. When it reaches 0, perform the access and go to RESP. req_ready=0.
- RESP: resp_valid=1 and outputs are held stable until resp_ready=1 at a clock edge. Then return to IDLE.
  - req_ready stays 0 in RESP, so back-to-back requests are spaced by at least one IDLE cycle.
  - Minimum transaction length is LATENCY+1 cycles including the IDLE accept cycle.
- The access is performed exactly once, on the WAIT→RESP or IDLE→RESP edge.
  - Loads register resp_rdata at that edge.
  - Stores write the array at that edge.
- Error checks, all evaluated on the captured request:
  - Halfword access with addr[0]=1 → error.
  - Word access with addr[1:0]≠0 → error.
  - addr[DATA_WIDTH-1:2] ≥ DEPTH_WORDS → error.
  - func3 not in the legal set for the operation → error. Loads allow {000,001,010,100,101}; stores allow {000,001,010}.
  - On any error: no array write, resp_err=1, resp_rdata=0.
- Load data:
  - Select the byte or halfword by addr[1:0] (little-endian).
  - B/H are sign-extended; BU/HU are zero-extended; W is returned unchanged.
- Store data:
  - SB writes only byte lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all four lanes.
  - Unselected lanes are unchanged.
- Reset asserted in WAIT or RESP aborts the transaction. No write is committed if reset arrives before the commit edge, and no response is produced.
- Inputs are ignored outside IDLE; a changing req_* while not accepted has no effect.

Test Plan:
- LATENCY=2: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → each resp_valid 2 cycles after accept; load resp_rdata=0xDEADBEEF, resp_err=0.
- After the above, LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE; LH 0x12 → 0xFFFFDEAD; LHU 0x10 → 0x0000BEEF.
- SB 0x11 data 0x55, then LW 0x10 → 0xDEAD55EF. SH 0x12 data 0x1234, then LW 0x10 → 0x123455EF.
- Error cases, all with no state change:
  - LW 0x12 → resp_err=1, rdata=0.
  - SH 0x13 → resp_err=1, and a following LW 0x10 still returns 0x123455EF.
  - LW (DEPTH_WORDS*4) → resp_err=1.
- Hold resp_ready=0 for 5 cycles in RESP → resp_valid, rdata and err stay stable; req_ready=0 and busy=1 throughout; a req_valid pulse is ignored.
- Assert rst=0 mid-WAIT on an SW 0x20 data 0xAAAAAAAA → outputs return to reset values immediately (asynchronously); after release, LW 0x20 returns the prior contents, not 0xAAAAAAAA.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder
//   Handshaked, multi-cycle data-memory responder for the MEM-stage
//   load/store channel. One load or store is accepted per transaction,
//   RV32I func3 width/sign rules are applied, and the response (read data
//   or store acknowledgement) is presented LATENCY cycles after acceptance.
//   Misaligned, out-of-range and illegal-func3 accesses are reported via
//   resp_err and never touch the storage array.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   req_valid   request present
//   req_ready   responder idle and able to accept a request
//   req_we      1 = store, 0 = load
//   req_func3   000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr    byte address
//   req_wdata   store data, LSB-aligned
//   resp_valid  response present (held until resp_ready)
//   resp_ready  requester accepts the response
//   resp_rdata  extended load data; 0 for stores and errors
//   resp_err    access misaligned, out of range or illegal func3
//   busy        high whenever not idle (pipeline stall source)

module dmem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_func3,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic                  accept, commit;

  logic                  cap_we;
  logic [2:0]            cap_func3;
  logic [DATA_WIDTH-1:0] cap_addr, cap_wdata;

  logic                  acc_we;
  logic [2:0]            acc_func3;
  logic [DATA_WIDTH-1:0] acc_addr, acc_wdata;

  logic [AW-1:0]         word_idx;
  logic                  misaligned, out_of_range, bad_func3, acc_err;
  logic [DATA_WIDTH-1:0] mem_word, load_data;
  logic [7:0]            load_byte;
  logic [15:0]           load_half;
  logic [3:0]            lane_mask;
  logic [DATA_WIDTH-1:0] lane_data;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  // FSM next state; commit marks the single edge on which the access happens
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          cnt_nxt = CW'(LATENCY - 1);
          if (LATENCY == 1) begin
            commit    = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          commit    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With LATENCY=1 the access happens on the accept edge, before the capture
  // registers hold the request, so the live request is used in IDLE.
  always_comb begin
    if (state == IDLE) begin
      acc_we    = req_we;
      acc_func3 = req_func3;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end else begin
      acc_we    = cap_we;
      acc_func3 = cap_func3;
      acc_addr  = cap_addr;
      acc_wdata = cap_wdata;
    end
  end

  // Error classification
  always_comb begin
    word_idx     = acc_addr[2 +: AW];
    out_of_range = |acc_addr[DATA_WIDTH-1:AW+2];
    case (acc_func3[1:0])
      2'b01:   misaligned = acc_addr[0];
      2'b10:   misaligned = |acc_addr[1:0];
      default: misaligned = 1'b0;
    endcase
    if (acc_we)
      bad_func3 = acc_func3[2] | (acc_func3[1:0] == 2'b11);
    else
      bad_func3 = (acc_func3 == 3'b011) | (acc_func3[2:1] == 2'b11);
    acc_err = misaligned | out_of_range | bad_func3;
  end

  // Load extraction (little-endian lane select, then extension)
  always_comb begin
    mem_word  = mem[word_idx];
    load_byte = mem_word[{acc_addr[1:0], 3'b000} +: 8];
    load_half = acc_addr[1] ? mem_word[31:16] : mem_word[15:0];
    case (acc_func3)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_data = {24'h0, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b101:  load_data = {16'h0, load_half};
      3'b010:  load_data = mem_word;
      default: load_data = '0;
    endcase
  end

  // Store lane enables; data is replicated so each lane sees its own bytes
  always_comb begin
    case (acc_func3[1:0])
      2'b00: begin
        lane_mask = 4'b0001 << acc_addr[1:0];
        lane_data = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        lane_mask = acc_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{acc_wdata[15:0]}};
      end
      default: begin
        lane_mask = 4'b1111;
        lane_data = acc_wdata;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cap_we     <= 1'b0;
      cap_func3  <= '0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        cap_we    <= req_we;
        cap_func3 <= req_func3;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
      end
      if (commit) begin
        resp_err   <= acc_err;
        resp_rdata <= (acc_we || acc_err) ? '0 : load_data;
      end else if (state == RESP && resp_ready) begin
        resp_err   <= 1'b0;
        resp_rdata <= '0;
      end
    end
  end

  // Storage array is not reset
  always_ff @(posedge clk) begin
    if (commit && acc_we && !acc_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lane_mask[i]) mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed table, hand-written
// back-pressure and mid-transaction reset sequences, then randomized
// traffic compared against a byte-array reference model.

module tb_dmem_responder;

  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam int WIN   = 64;  // bytes covered by the reference model

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_func3 = '0;
  logic [DW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic          busy;

  always #5 clk = ~clk;

  dmem_responder #(
    .DATA_WIDTH (DW),
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_func3 (req_func3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .busy      (busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete transaction with resp_ready held high.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic e,
                      output int lat);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_func3 = f3;
    req_addr  = a;
    req_wdata = wd;
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    // Junk on the request bus while busy must be ignored
    req_valid = 1'($urandom);
    req_we    = 1'($urandom);
    req_func3 = 3'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    req_valid = 1'b0;
    if (!resp_valid) begin
      errors++;
      checks++;
      $display("FAIL resp_timeout: got no resp_valid within %0d cycles, required %0d", lat, LAT);
      rd = '0;
      e  = 1'b0;
      return;
    end
    rd = resp_rdata;
    e  = resp_err;
    @(posedge clk);
    #1;
    chk("resp_released", {31'b0, resp_valid}, 32'd0);
  endtask

  // Reference model: byte-addressed window plus RV32I access rules.
  logic [7:0] ref_mem [WIN];

  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd, output logic e);
    int size = 1;
    bit sgn = 0;
    bit legal = 1;
    logic [31:0] v = 0;
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: begin size = 4; sgn = 0; end
      3'd4: begin size = 1; sgn = 0; legal = !we; end
      3'd5: begin size = 2; sgn = 0; legal = !we; end
      default: legal = 0;
    endcase
    e  = !legal || (a % size != 0) || (a / 4 >= DEPTH);
    rd = 0;
    if (e) return;
    if (we) begin
      for (int k = 0; k < size; k++) ref_mem[a + k] = wd[8*k +: 8];
    end else begin
      for (int k = 0; k < size; k++) v = v | (32'(ref_mem[a + k]) << (8 * k));
      if (sgn && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
      rd = v;
    end
  endfunction

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl [18];

  initial begin
    #600000;
    $display("FAIL global_timeout: got simulation still running, required completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, exp_rd, hold_rd;
    logic        e, exp_e;
    int          lat;

    tbl[0]  = '{"sw_10",     1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        0};
    tbl[1]  = '{"lw_10",     0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 0};
    tbl[2]  = '{"lb_13",     0, 3'b000, 32'h13,   32'h0,        32'hFFFFFFDE, 0};
    tbl[3]  = '{"lbu_13",    0, 3'b100, 32'h13,   32'h0,        32'h000000DE, 0};
    tbl[4]  = '{"lh_12",     0, 3'b001, 32'h12,   32'h0,        32'hFFFFDEAD, 0};
    tbl[5]  = '{"lhu_10",    0, 3'b101, 32'h10,   32'h0,        32'h0000BEEF, 0};
    tbl[6]  = '{"sb_11",     1, 3'b000, 32'h11,   32'h55,       32'h0,        0};
    tbl[7]  = '{"lw_after_sb", 0, 3'b010, 32'h10, 32'h0,        32'hDEAD55EF, 0};
    tbl[8]  = '{"sh_12",     1, 3'b001, 32'h12,   32'h1234,     32'h0,        0};
    tbl[9]  = '{"lw_after_sh", 0, 3'b010, 32'h10, 32'h0,        32'h123455EF, 0};
    tbl[10] = '{"lw_mis_12", 0, 3'b010, 32'h12,   32'h0,        32'h0,        1};
    tbl[11] = '{"sh_mis_13", 1, 3'b001, 32'h13,   32'hFFFF,     32'h0,        1};
    tbl[12] = '{"lw_after_err", 0, 3'b010, 32'h10, 32'h0,       32'h123455EF, 0};
    tbl[13] = '{"lw_oor",    0, 3'b010, DEPTH*4,  32'h0,        32'h0,        1};
    tbl[14] = '{"sbu_illegal", 1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0,        1};
    tbl[15] = '{"ld_f3_011", 0, 3'b011, 32'h10,   32'h0,        32'h0,        1};
    tbl[16] = '{"lw_after_ill", 0, 3'b010, 32'h10, 32'h0,       32'h123455EF, 0};
    tbl[17] = '{"sw_20",     1, 3'b010, 32'h20,   32'h01020304, 32'h0,        0};

    // Reset values
    #2 rst = 1'b0;
    #1;
    chk("rst_req_ready",  {31'b0, req_ready},  32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_busy",       {31'b0, busy},       32'd0);
    chk("rst_resp_err",   {31'b0, resp_err},   32'd0);
    chk("rst_resp_rdata", resp_rdata,          32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Directed table
    for (int i = 0; i < 18; i++) begin
      xact(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, rd, e, lat);
      chk({tbl[i].name, "_rdata"}, rd, tbl[i].exp_rd);
      chk({tbl[i].name, "_err"}, {31'b0, e}, {31'b0, tbl[i].exp_err});
      chk({tbl[i].name, "_latency"}, lat, LAT);
    end

    // Back-pressure: response held stable, request pulse ignored
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b010; req_addr = 32'h10;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("hold_latency", lat, LAT);
    hold_rd = 32'h123455EF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = (i == 2); req_we = 1'b1; req_func3 = 3'b010;
      req_addr = 32'h10; req_wdata = 32'h0;
      chk("hold_valid", {31'b0, resp_valid}, 32'd1);
      chk("hold_rdata", resp_rdata, hold_rd);
      chk("hold_err", {31'b0, resp_err}, 32'd0);
      chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
      chk("hold_busy", {31'b0, busy}, 32'd1);
    end
    @(negedge clk);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_release_valid", {31'b0, resp_valid}, 32'd0);
    chk("hold_release_ready", {31'b0, req_ready}, 32'd1);
    xact(1'b0, 3'b010, 32'h10, 32'h0, rd, e, lat);
    chk("lw_after_hold", rd, 32'h123455EF);

    // Reset mid-WAIT aborts the store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_func3 = 3'b010;
    req_addr = 32'h20; req_wdata = 32'hAAAAAAAA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("abort_busy_wait", {31'b0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("abort_req_ready",  {31'b0, req_ready},  32'd1);
    chk("abort_busy",       {31'b0, busy},       32'd0);
    chk("abort_rdata",      resp_rdata,          32'd0);
    chk("abort_err",        {31'b0, resp_err},   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    xact(1'b0, 3'b010, 32'h20, 32'h0, rd, e, lat);
    chk("lw_after_abort", rd, 32'h01020304);
    chk("lw_after_abort_err", {31'b0, e}, 32'd0);

    // Fill the model window with known data
    for (int w = 0; w < WIN / 4; w++) begin
      logic [31:0] d;
      d = $urandom;
      model(1'b1, 3'b010, 32'(4 * w), d, exp_rd, exp_e);
      xact(1'b1, 3'b010, 32'(4 * w), d, rd, e, lat);
      chk("init_err", {31'b0, e}, {31'b0, exp_e});
    end

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a, wd;
      int          r;
      we = 1'($urandom);
      r  = $urandom_range(0, 3);
      if (r == 0) f3 = 3'($urandom);
      else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end
      r = $urandom_range(0, 9);
      if (r == 0)      a = DEPTH * 4 + $urandom_range(0, 4095);
      else if (r == 1) a = 32'h8000_0000 | $urandom;
      else             a = $urandom_range(0, WIN - 1);
      wd = $urandom;
      model(we, f3, a, wd, exp_rd, exp_e);
      xact(we, f3, a, wd, rd, e, lat);
      chk("rand_rdata", rd, exp_rd);
      chk("rand_err", {31'b0, e}, {31'b0, exp_e});
      chk("rand_latency", lat, LAT);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
